// File: rtl/rx_stamp_capture.sv
// Time-stamped UART byte capture: tags each received byte with the current stamp and a
// start-of-frame flag (frames delimited by idle gaps), buffered in a show-ahead FIFO.
module rx_stamp_capture #(
  parameter int          DEPTH      = 8,
  parameter logic [15:0] GAP_CYCLES = 16'd400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte_i,
  input  logic                     rx_valid_i,
  input  logic [3:0]               acqurate_stamp_i,
  input  logic [11:0]              millisecond_stamp_i,
  input  logic [31:0]              second_stamp_i,
  input  logic                     clear_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [7:0]               out_byte_o,
  output logic                     out_sof_o,
  output logic [3:0]               out_acqurate_o,
  output logic [11:0]              out_ms_o,
  output logic [31:0]              out_sec_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 57;

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t          state_q, state_d;
  logic [15:0]     gap_q, gap_d;
  logic            pending_sof_q, pending_sof_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [EW-1:0]   head_q, head_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            full;
  logic            pop;
  logic            frame_start;
  logic            wr_en;
  logic [EW-1:0]   wr_entry;

  assign full        = (count_q == CW'(DEPTH));
  assign pop         = (count_q != '0) && out_ready_i;
  assign frame_start = (state_q == IDLE) && rx_valid_i;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en       = rx_valid_i && !clear_i && (!full || pop);
  assign wr_entry    = {(frame_start || pending_sof_q), rx_byte_i, acqurate_stamp_i,
                        millisecond_stamp_i, second_stamp_i};

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    pending_sof_d = pending_sof_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    head_d        = head_q;
    if (clear_i) begin
      state_d       = IDLE;
      gap_d         = '0;
      pending_sof_d = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      head_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid_i) begin
            state_d = IN_FRAME;
            gap_d   = '0;
          end
        end
        IN_FRAME: begin
          if (rx_valid_i) begin
            gap_d = '0;
          end else if (gap_q == GAP_CYCLES - 16'd1) begin
            state_d = IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      // sof survives a dropped first byte until some byte of the frame is stored.
      if (wr_en) begin
        pending_sof_d = 1'b0;
      end else if (frame_start) begin
        pending_sof_d = 1'b1;
      end

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);

      if (rx_valid_i && full && !pop) overflow_d = 1'b1;

      // New entry bypasses memory when it becomes the head immediately.
      if (wr_en && ((count_q - CW'(pop)) == '0)) begin
        head_d = wr_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      pending_sof_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      head_q        <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      pending_sof_q <= pending_sof_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      head_q        <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign {out_sof_o, out_byte_o, out_acqurate_o, out_ms_o, out_sec_o} = head_q;
  assign out_valid_o  = (count_q != '0);
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_rx_stamp_capture.sv
// Directed bench for rx_stamp_capture (DEPTH=8, GAP_CYCLES=4) with immediate-assertion checks.
module tb_rx_stamp_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte_i;
  logic        rx_valid_i;
  logic [3:0]  acqurate_stamp_i;
  logic [11:0] millisecond_stamp_i;
  logic [31:0] second_stamp_i;
  logic        clear_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_byte_o;
  logic        out_sof_o;
  logic [3:0]  out_acqurate_o;
  logic [11:0] out_ms_o;
  logic [31:0] out_sec_o;
  logic [3:0]  fifo_count_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  rx_stamp_capture #(.DEPTH(8), .GAP_CYCLES(16'd4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_byte_i           (rx_byte_i),
    .rx_valid_i          (rx_valid_i),
    .acqurate_stamp_i    (acqurate_stamp_i),
    .millisecond_stamp_i (millisecond_stamp_i),
    .second_stamp_i      (second_stamp_i),
    .clear_i             (clear_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_byte_o          (out_byte_o),
    .out_sof_o           (out_sof_o),
    .out_acqurate_o      (out_acqurate_o),
    .out_ms_o            (out_ms_o),
    .out_sec_o           (out_sec_o),
    .fifo_count_o        (fifo_count_o),
    .overflow_o          (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_byte, input logic exp_sof);
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_byte"},  64'(out_byte_o),  64'(exp_byte));
    chk({tag, "_sof"},   64'(out_sof_o),   64'(exp_sof));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_byte_i = 8'hEE; rx_valid_i = 1'b1; clear_i = 1'b0; out_ready_i = 1'b0;
    acqurate_stamp_i = 4'd3; millisecond_stamp_i = 12'd250; second_stamp_i = 32'd7;

    // Reset with rx_valid asserted: byte ignored, everything cleared
    idle(2);
    rst = 1'b1; rx_valid_i = 1'b0;
    tick();
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o),  64'd0);
    chk("rst_byte",  64'(out_byte_o),   64'd0);
    chk("rst_sof",   64'(out_sof_o),    64'd0);
    chk("rst_ovf",   64'(overflow_o),   64'd0);
    $display("txn reset: count=%0d valid=%0d", fifo_count_o, out_valid_o);

    // Single byte with stamp (3,250,7), visible the next cycle
    send(8'hA5);
    chk("single_valid", 64'(out_valid_o),    64'd1);
    chk("single_byte",  64'(out_byte_o),     64'hA5);
    chk("single_sof",   64'(out_sof_o),      64'd1);
    chk("single_acq",   64'(out_acqurate_o), 64'd3);
    chk("single_ms",    64'(out_ms_o),       64'd250);
    chk("single_sec",   64'(out_sec_o),      64'd7);
    chk("single_count", 64'(fifo_count_o),   64'd1);
    $display("txn single: byte=%0h sof=%0d", out_byte_o, out_sof_o);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    chk("single_empty", 64'(out_valid_o), 64'd0);
    idle(10);

    // Framing: 0x01, 0x02 three cycles later (same frame), 0x03 ten cycles after that
    send(8'h01);
    idle(2);
    send(8'h02);
    idle(9);
    send(8'h03);
    chk("frame_count", 64'(fifo_count_o), 64'd3);
    pop_check("frame0", 8'h01, 1'b1);
    pop_check("frame1", 8'h02, 1'b0);
    pop_check("frame2", 8'h03, 1'b1);
    chk("frame_empty", 64'(out_valid_o), 64'd0);
    $display("txn framing: sof pattern 1,0,1 checked");
    idle(10);

    // Overflow: ten bytes into an 8-deep FIFO with no reader
    for (int i = 0; i < 10; i++) send(8'(i));
    chk("ovf_count", 64'(fifo_count_o), 64'd8);
    chk("ovf_flag",  64'(overflow_o),   64'd1);
    for (int i = 0; i < 8; i++) pop_check("ovf_drain", 8'(i), (i == 0));
    chk("ovf_empty",  64'(out_valid_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o),  64'd1);
    $display("txn overflow: drained 8, flag sticky=%0d", overflow_o);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("ovf_cleared", 64'(overflow_o), 64'd0);
    idle(10);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    chk("pp_full", 64'(fifo_count_o), 64'd8);
    rx_byte_i = 8'h55; rx_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("pp_count", 64'(fifo_count_o), 64'd8);
    chk("pp_ovf",   64'(overflow_o),   64'd0);
    for (int i = 1; i < 8; i++) pop_check("pp_drain", 8'h20 + 8'(i), 1'b0);
    pop_check("pp_last", 8'h55, 1'b0);
    chk("pp_empty", 64'(out_valid_o), 64'd0);
    $display("txn push_pop_full: 0x55 read last");
    idle(10);

    // Dropped start-of-frame: 0x10 dropped while full, 0x11 of same frame gets sof
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    idle(10);
    send(8'h10);
    chk("dsof_ovf",   64'(overflow_o),   64'd1);
    chk("dsof_count", 64'(fifo_count_o), 64'd8);
    chk("dsof_head",  64'(out_byte_o),   64'h30);
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
    send(8'h11);
    chk("dsof_count2", 64'(fifo_count_o), 64'd8);
    for (int i = 1; i < 8; i++) pop_check("dsof_drain", 8'h30 + 8'(i), 1'b0);
    pop_check("dsof_11", 8'h11, 1'b1);
    $display("txn dropped_sof: 0x11 stored with sof=1");
    idle(10);

    // Clear priority: overflow still set from above, three entries stored
    send(8'h40); send(8'h41); send(8'h42);
    chk("clr_pre_count", 64'(fifo_count_o), 64'd3);
    chk("clr_pre_ovf",   64'(overflow_o),   64'd1);
    rx_byte_i = 8'h77; rx_valid_i = 1'b1; clear_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; clear_i = 1'b0;
    chk("clr_count", 64'(fifo_count_o), 64'd0);
    chk("clr_valid", 64'(out_valid_o),  64'd0);
    chk("clr_ovf",   64'(overflow_o),   64'd0);
    tick();
    chk("clr_no77", 64'(out_valid_o), 64'd0);
    send(8'h78);
    pop_check("clr_next", 8'h78, 1'b1);
    $display("txn clear: count=%0d ovf=%0d", fifo_count_o, overflow_o);

    // Reset mid-frame with data stored
    send(8'h90); send(8'h91);
    rst = 1'b0; rx_byte_i = 8'h92; rx_valid_i = 1'b1;
    tick();
    rst = 1'b1; rx_valid_i = 1'b0;
    chk("mrst_count", 64'(fifo_count_o), 64'd0);
    chk("mrst_byte",  64'(out_byte_o),   64'd0);
    send(8'h99);
    chk("mrst_count1", 64'(fifo_count_o), 64'd1);
    pop_check("mrst_first", 8'h99, 1'b1);
    $display("txn mid_reset: first byte after release has sof");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_stamp_capture.md
RX_STAMP_CAPTURE -- requirements
Module: rx_stamp_capture

Interface
REQ-001 Parameter DEPTH, 8, number of FIFO entries; power of two, 2..64.
REQ-002 Parameter GAP_CYCLES, 16'd400, idle clk cycles after the last received byte that end a frame; range 1..65535.
REQ-003 clk  input  1  system clock, >=40 MHz.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 rx_byte_i  input  8  received UART byte.
REQ-006 rx_valid_i  input  1  one-cycle strobe; rx_byte_i valid this cycle.
REQ-007 acqurate_stamp_i  input  4  time-stamp 0.1 ms digit, 0..9.
REQ-008 millisecond_stamp_i  input  12  time-stamp ms field, 0..999.
REQ-009 second_stamp_i  input  32  time-stamp seconds field.
REQ-010 clear_i  input  1  flushes the FIFO, clears overflow_o and forces the frame FSM to IDLE.
REQ-011 out_valid_o  output  1  head entry available.
REQ-012 out_ready_i  input  1  consumer accepts the head entry when it is high together with out_valid_o.
REQ-013 out_byte_o  output  8  head entry data byte.
REQ-014 out_sof_o  output  1  head entry is the first stored byte of a frame.
REQ-015 out_acqurate_o / out_ms_o / out_sec_o  output  4/12/32  head entry stamp.
REQ-016 fifo_count_o  output  log2(DEPTH)+1  number of stored entries.
REQ-017 overflow_o  output  1  sticky flag; set when a byte is dropped because the FIFO is full.

Function
REQ-018 Entry = {sof, byte[7:0], acqurate[3:0], ms[11:0], sec[31:0]} (57 bits); the stamp inputs are sampled in the same clk cycle as rx_valid_i.
REQ-019 Frame FSM has two states, IDLE and IN_FRAME:
- IDLE -> IN_FRAME on rx_valid_i.
- IN_FRAME -> IDLE when the 16-bit gap counter reaches GAP_CYCLES-1 with no rx_valid_i.
REQ-020 Gap counter:
- Clears to 0 on each rx_valid_i.
- Increments by 1 each cycle in IN_FRAME otherwise.
- Holds at 0 in IDLE.
- Never wraps.
REQ-021 pending_sof register:
- Set on the IDLE -> IN_FRAME transition.
- The next accepted write stores sof=1 and clears pending_sof.
- If the first byte of a frame is dropped while the FIFO is full, the first byte of that frame that is accepted carries sof=1.
REQ-022 Write: rx_valid_i with FIFO not full stores the entry; count +1.
REQ-023 Full: rx_valid_i with count==DEPTH and no pop in the same cycle drops the byte, sets overflow_o and leaves FIFO contents unchanged.
REQ-024 Full with pop in the same cycle: the write is accepted; count stays DEPTH; overflow_o is not set.
REQ-025 Pop: out_valid_o && out_ready_i removes the head entry; the next entry is presented on the following cycle.
REQ-026 Output is show-ahead and registered, with no combinational path from rx to out:
- A write into an empty FIFO at cycle N gives out_valid_o=1 at cycle N+1.
- Simultaneous push/pop with count==1 keeps out_valid_o=1 and presents the new entry at N+1.
REQ-027 out_* data is stable while out_valid_o=1 and out_ready_i=0.
REQ-028 out_valid_o = (count != 0).
REQ-029 fifo_count_o is updated on the cycle after each push/pop and is never above DEPTH.
REQ-030 Read/write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-031 clear_i has priority over rx_valid_i and pop in the same cycle:
- Next cycle: count=0, out_valid_o=0, overflow_o=0, FSM=IDLE, gap counter=0, pending_sof=0.
- A byte presented with clear_i is discarded and does not set overflow.
REQ-032 overflow_o stays high until clear_i or rst.

Reset
REQ-033 While rst=0 at a clk edge, the following are cleared:
- Pointers, count, gap counter, pending_sof, overflow_o.
- FSM -> IDLE.
- out_valid_o=0; out_byte_o, out_sof_o, out_acqurate_o, out_ms_o, out_sec_o all 0; fifo_count_o=0.
REQ-034 Reset asserted mid-frame or with the FIFO non-empty discards all entries; the first byte after release carries sof=1.
REQ-035 rx_valid_i during reset is ignored.

Verification
REQ-036 Single byte: reset; stamp=(3,250,7); rx 0xA5 at cycle N -> at N+1 out_valid_o=1, byte=0xA5, sof=1, stamp=(3,250,7), count=1.
REQ-037 Framing with GAP_CYCLES=4:
- Stimulus: bytes 0x01, 0x02 three cycles apart, then 0x03 ten cycles later.
- Required response: sof flags 1, 0, 1.
REQ-038 Overflow with DEPTH=8 and out_ready_i=0:
- Stimulus: 10 bytes 0x00..0x09.
- Required response: count=8; overflow_o=1.
- Then drain with out_ready_i=1: out_byte_o yields 0x00..0x07 in order; out_valid_o falls after the 8th pop.
REQ-039 Full + simultaneous push/pop:
- Stimulus: FIFO full; rx 0x55 while popping.
- Required response: count stays 8; overflow_o=0; 0x55 is read as the last entry.
REQ-040 Dropped SOF:
- Stimulus: FIFO full, FSM in IDLE; a new frame's first byte 0x10 is dropped; one entry is popped; the next byte 0x11 arrives in the same frame.
- Required response: 0x11 is stored with sof=1.
REQ-041 Clear priority:
- Stimulus: 3 entries stored, overflow_o=1; clear_i together with rx 0x77.
- Required response: next cycle count=0, out_valid_o=0, overflow_o=0; 0x77 never appears at the output; the next byte has sof=1.
